// File: rtl/riscv_pkg.sv
// Shared core definitions for the fetch and decode stages.
//   XLEN / ILEN       : data-path and instruction widths
//   RESET_PC_DEFAULT  : program counter value loaded on reset
//   slot_t            : one fetch-buffer entry {pc, inst, filled}
package riscv_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            filled;
  } slot_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, branch
// redirect from execute, and the decode handoff.
//   master : fetch stage side (drives requests and decode outputs)
//   slave  : environment side (memory, execute, decode)
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           br_taken, br_target, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           br_taken, br_target, id_ready
  );
endinterface

// File: rtl/fetch_slot_queue.sv
// Circular buffer of fetch slots.
//   alloc_i/alloc_pc_i : reserve the tail slot for a newly accepted request
//   fill_i/fill_inst_i : write a returning word into the oldest unfilled slot
//   pop_i              : release the head slot (decode consumed it)
//   flush_i            : invalidate every slot (redirect); overrides all else
//   head_o             : current head slot
//   used_o             : allocated slot count
//   unfilled_o         : allocated slots still waiting for their word
module fetch_slot_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_i,
  input  logic [XLEN-1:0]              alloc_pc_i,
  input  logic                         fill_i,
  input  logic [ILEN-1:0]              fill_inst_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output slot_t                        head_o,
  output logic [$clog2(DEPTH+1)-1:0]   used_o,
  output logic [$clog2(DEPTH+1)-1:0]   unfilled_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  slot_t         slots_q [DEPTH];
  slot_t         slots_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0] used_q, used_d, unfilled_q, unfilled_d;
  logic          fill_ok;

  // A word with no waiting slot must never clobber a live entry.
  assign fill_ok = fill_i && (unfilled_q != '0);

  always_comb begin
    slots_d    = slots_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    used_d     = used_q;
    unfilled_d = unfilled_q;
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) slots_d[PW'(i)].filled = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      used_d     = '0;
      unfilled_d = '0;
    end else begin
      if (alloc_i) begin
        slots_d[tail_q] = '{pc: alloc_pc_i, inst: '0, filled: 1'b0};
        tail_d          = tail_q + PW'(1);
      end
      if (fill_ok) begin
        slots_d[fill_q].inst   = fill_inst_i;
        slots_d[fill_q].filled = 1'b1;
        fill_d                 = fill_q + PW'(1);
      end
      // Clearing on pop keeps a stale filled flag from a previous lap out of
      // id_valid when the queue drains to empty.
      if (pop_i) begin
        slots_d[head_q].filled = 1'b0;
        head_d                 = head_q + PW'(1);
      end
      used_d     = used_q + CW'(alloc_i) - CW'(pop_i);
      unfilled_d = unfilled_q + CW'(alloc_i) - CW'(fill_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) slots_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      used_q     <= '0;
      unfilled_q <= '0;
    end else begin
      slots_q    <= slots_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      used_q     <= used_d;
      unfilled_q <= unfilled_d;
    end
  end

  assign head_o     = slots_q[head_q];
  assign used_o     = used_q;
  assign unfilled_o = unfilled_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word-aligned in-order fetches,
// buffers returned words in fetch_slot_queue and hands them to decode.
// A redirect flushes buffered slots and counts in-flight responses to drop.
//   clk, rst : core clock, asynchronous active-high reset
//   bus      : fetch_stage_if.master (imem req/rsp, redirect, decode handoff)
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int unsigned CW   = $clog2(DEPTH+1);
  localparam int unsigned DW   = $clog2(2*DEPTH+1);
  localparam int unsigned SW   = DW + 1;
  localparam int unsigned DMAX = 2*DEPTH;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic [SW-1:0]   drop_sum;
  slot_t           head;
  logic [CW-1:0]   used, unfilled;
  logic            req_fire, rsp_drop, rsp_fill, rsp_kill, pop;
  logic            unused_tgt_lsbs;

  assign bus.imem_req_valid = !rst && !bus.br_taken && (used < CW'(DEPTH));
  assign bus.imem_req_addr  = pc_q;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop = bus.imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = bus.imem_rsp_valid && (drop_q == '0) && !bus.br_taken;
  // A current word landing on the redirect cycle retires one unfilled slot.
  assign rsp_kill = bus.imem_rsp_valid && (drop_q == '0) && (unfilled != '0);
  assign pop      = head.filled && bus.id_ready && !bus.br_taken;

  assign bus.id_valid = head.filled;
  assign bus.id_inst  = head.inst;
  assign bus.id_pc    = head.pc;

  assign unused_tgt_lsbs = ^bus.br_target[1:0];

  always_comb begin
    pc_d     = pc_q;
    drop_d   = drop_q;
    drop_sum = '0;
    if (bus.br_taken) begin
      pc_d     = {bus.br_target[XLEN-1:2], 2'b00};
      drop_sum = SW'(unfilled) + SW'(drop_q) - SW'(rsp_drop) - SW'(rsp_kill);
      drop_d   = (drop_sum > SW'(DMAX)) ? DW'(DMAX) : drop_sum[DW-1:0];
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rsp_drop) drop_d = drop_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_slot_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .alloc_i    (req_fire),
    .alloc_pc_i (pc_q),
    .fill_i     (rsp_fill),
    .fill_inst_i(bus.imem_rsp_data),
    .pop_i      (pop),
    .flush_i    (bus.br_taken),
    .head_o     (head),
    .used_o     (used),
    .unfilled_o (unfilled)
  );

  a_rsp_has_home: assert property (@(posedge clk) disable iff (rst)
    !(bus.imem_rsp_valid && (drop_q == '0) && (unfilled == '0)));
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int unsigned due;
  } ent_t;

  ent_t        slots[$];  // current-epoch fetches, oldest first
  ent_t        memq[$];   // every accepted request still owed a response
  int unsigned cyc, last_due, lat_min, lat_max;
  int unsigned n_cmp, n_bad;
  bit          inst_mode;
  logic [31:0] exp_pc, seq_pc;
  logic        e_req_valid, e_id_valid, o_req_valid, o_id_valid;
  logic [31:0] e_addr, e_id_pc, e_id_inst, o_addr, o_id_pc, o_id_inst;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return inst_mode ? ((a * 32'h9E37_79B1) ^ 32'h0000_0013) : 32'h0000_0013;
  endfunction

  // One clock cycle: memory drives, expectations are formed from the
  // reference model, outputs are sampled at negedge, then the model advances.
  task automatic tick();
    int unsigned due;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memfn(memq[0].pc);
      void'(memq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    e_req_valid = !rst && !bus.br_taken && (slots.size() < DEPTH);
    e_addr      = exp_pc;
    e_id_valid  = !rst && (slots.size() > 0) && (slots[0].due < cyc);
    e_id_pc     = (slots.size() > 0) ? slots[0].pc : 32'h0;
    e_id_inst   = memfn(e_id_pc);
    @(negedge clk);
    o_req_valid = bus.imem_req_valid;
    o_addr      = bus.imem_req_addr;
    o_id_valid  = bus.id_valid;
    o_id_pc     = bus.id_pc;
    o_id_inst   = bus.id_inst;
    if (rst) begin
      slots.delete(); memq.delete(); exp_pc = RESET_PC; last_due = 0;
    end else if (bus.br_taken) begin
      slots.delete();
      exp_pc = bus.br_target & ~32'h3;
    end else begin
      if (e_id_valid && bus.id_ready) void'(slots.pop_front());
      if (e_req_valid && bus.imem_req_ready) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        slots.push_back('{pc: exp_pc, due: due});
        memq.push_back('{pc: exp_pc, due: due});
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    memq.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    lat_min = 1; lat_max = 1; inst_mode = 1'b0;
    tick(); tick();
    n_cmp++;
    if (o_req_valid !== 1'b0 || o_id_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valids got req=%b id=%b exp 0/0", o_req_valid, o_id_valid);
    end
    n_cmp++;
    if (o_id_pc !== 32'h0 || o_id_inst !== 32'h0) begin
      n_bad++; $display("FAIL reset_id_data got pc=%h inst=%h exp 0/0", o_id_pc, o_id_inst);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    seq_pc = RESET_PC;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++;
        if (o_req_valid !== 1'b1 || o_addr !== RESET_PC) begin
          n_bad++; $display("FAIL stream_first_req got v=%b a=%h exp 1/%h", o_req_valid, o_addr, RESET_PC);
        end
      end
      if (i < 3) begin
        n_cmp++;
        if (o_id_valid !== (i == 2)) begin
          n_bad++; $display("FAIL stream_first_id i=%0d got %b exp %b", i, o_id_valid, (i == 2));
        end
      end
      n_cmp++;
      if (o_req_valid !== e_req_valid || (e_req_valid && o_addr !== e_addr)) begin
        n_bad++; $display("FAIL stream_req cyc=%0d got v=%b a=%h exp v=%b a=%h", cyc, o_req_valid, o_addr, e_req_valid, e_addr);
      end
      n_cmp++;
      if (o_id_valid !== e_id_valid) begin
        n_bad++; $display("FAIL stream_id_valid cyc=%0d got %b exp %b", cyc, o_id_valid, e_id_valid);
      end
      if (o_id_valid) begin
        n_cmp++;
        if (o_id_pc !== seq_pc || o_id_inst !== 32'h0000_0013) begin
          n_bad++; $display("FAIL stream_seq got pc=%h inst=%h exp pc=%h inst=00000013", o_id_pc, o_id_inst, seq_pc);
        end
        seq_pc = seq_pc + 32'd4;
      end
    end
  endtask

  task automatic test_stall();
    bus.id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (o_req_valid !== e_req_valid) begin
        n_bad++; $display("FAIL stall_req cyc=%0d got %b exp %b", cyc, o_req_valid, e_req_valid);
      end
      if (o_id_valid) begin
        n_cmp++;
        if (o_id_pc !== seq_pc || o_id_inst !== 32'h0000_0013) begin
          n_bad++; $display("FAIL stall_hold got pc=%h exp %h", o_id_pc, seq_pc);
        end
      end
    end
    n_cmp++;
    if (o_id_valid !== 1'b1 || o_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL stall_full got id=%b req=%b exp 1/0", o_id_valid, o_req_valid);
    end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_id_valid) begin
        n_cmp++;
        if (o_id_pc !== seq_pc) begin
          n_bad++; $display("FAIL stall_resume got pc=%h exp %h", o_id_pc, seq_pc);
        end
        seq_pc = seq_pc + 32'd4;
      end
    end
  endtask

  task automatic test_redirect();
    bit first = 1'b1;
    pulse_reset();
    inst_mode = 1'b1; lat_min = 4; lat_max = 4; bus.id_ready = 1'b1;
    tick(); tick();
    bus.br_taken = 1'b1; bus.br_target = 32'h0000_0103;
    tick();
    bus.br_taken = 1'b0;
    n_cmp++;
    if (o_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL redir_no_req got %b exp 0", o_req_valid);
    end
    tick();
    n_cmp++;
    if (o_id_valid !== 1'b0 || o_req_valid !== 1'b1 || o_addr !== 32'h0000_0100) begin
      n_bad++; $display("FAIL redir_next got id=%b req=%b a=%h exp 0/1/00000100", o_id_valid, o_req_valid, o_addr);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (o_id_valid !== e_id_valid || (e_id_valid && (o_id_pc !== e_id_pc || o_id_inst !== e_id_inst))) begin
        n_bad++; $display("FAIL redir_id cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h", cyc, o_id_valid, o_id_pc, o_id_inst, e_id_valid, e_id_pc, e_id_inst);
      end
      if (o_id_valid && first) begin
        first = 1'b0;
        n_cmp++;
        if (o_id_pc !== 32'h0000_0100) begin
          n_bad++; $display("FAIL redir_first_pc got %h exp 00000100", o_id_pc);
        end
      end
    end
    n_cmp++;
    if (first) begin
      n_bad++; $display("FAIL redir_live got no id_valid exp at least one");
    end
  endtask

  task automatic test_br_coincident();
    bit found = 1'b0, first = 1'b1;
    logic [31:0] tgt;
    pulse_reset();
    lat_min = 1; lat_max = 1; bus.id_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (slots.size() > 0 && slots[0].due < cyc && memq.size() > 0 && memq[0].due <= cyc) begin
        found = 1'b1;
        tgt = $urandom & 32'h0000_FFF0;
        bus.br_taken = 1'b1; bus.br_target = tgt | 32'h2;
      end
      tick();
      bus.br_taken = 1'b0;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL coinc_setup got no overlap exp overlap within 30 cycles");
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (o_id_valid !== e_id_valid || (e_id_valid && (o_id_pc !== e_id_pc || o_id_inst !== e_id_inst))) begin
        n_bad++; $display("FAIL coinc_id cyc=%0d got v=%b pc=%h exp v=%b pc=%h", cyc, o_id_valid, o_id_pc, e_id_valid, e_id_pc);
      end
      if (o_id_valid && first) begin
        first = 1'b0;
        n_cmp++;
        if (o_id_pc !== tgt) begin
          n_bad++; $display("FAIL coinc_first_pc got %h exp %h", o_id_pc, tgt);
        end
      end
    end
  endtask

  task automatic test_random();
    bit          wrap_seen = 1'b0, prev_br = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    int unsigned n_hs = 0;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 10000; i++) begin
      bus.br_taken       = !prev_br && ($urandom_range(99, 0) < 3);
      bus.br_target      = $urandom_range(1, 0) ? (32'hFFFF_FFE0 | $urandom_range(31, 0)) : $urandom;
      bus.id_ready       = ($urandom_range(99, 0) < 60);
      bus.imem_req_ready = ($urandom_range(99, 0) < 75);
      prev_br = bus.br_taken;
      tick();
      n_cmp++;
      if (o_req_valid !== e_req_valid || (e_req_valid && o_addr !== e_addr)) begin
        n_bad++; $display("FAIL rand_req cyc=%0d got v=%b a=%h exp v=%b a=%h", cyc, o_req_valid, o_addr, e_req_valid, e_addr);
      end
      n_cmp++;
      if (o_id_valid !== e_id_valid || (e_id_valid && (o_id_pc !== e_id_pc || o_id_inst !== e_id_inst))) begin
        n_bad++; $display("FAIL rand_id cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h", cyc, o_id_valid, o_id_pc, o_id_inst, e_id_valid, e_id_pc, e_id_inst);
      end
      if (bus.br_taken) prev_pc = 32'h0;
      else if (o_id_valid && bus.id_ready) begin
        if (prev_pc == 32'hFFFF_FFFC && o_id_pc == 32'h0) wrap_seen = 1'b1;
        prev_pc = o_id_pc;
        n_hs++;
      end
    end
    bus.imem_req_ready = 1'b1;
    n_cmp++;
    if (!wrap_seen || n_hs < 1000) begin
      n_bad++; $display("FAIL rand_progress got wrap=%b handshakes=%0d exp wrap=1 handshakes>=1000", wrap_seen, n_hs);
    end
  endtask

  task automatic test_reset_mid();
    bit first = 1'b1;
    lat_min = 1; lat_max = 1; bus.br_taken = 1'b0;
    bus.imem_req_ready = 1'b1; bus.id_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (o_id_valid !== 1'b1 || o_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_full got id=%b req=%b exp 1/0", o_id_valid, o_req_valid);
    end
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    memq.delete();
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0) begin
      n_bad++; $display("FAIL rstmid_async got req=%b id=%b pc=%h inst=%h exp 0/0/0/0", bus.imem_req_valid, bus.id_valid, bus.id_pc, bus.id_inst);
    end
    tick();
    rst = 1'b0;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++;
        if (o_req_valid !== 1'b1 || o_addr !== RESET_PC) begin
          n_bad++; $display("FAIL rstmid_restart got v=%b a=%h exp 1/%h", o_req_valid, o_addr, RESET_PC);
        end
      end
      if (o_id_valid && first) begin
        first = 1'b0;
        n_cmp++;
        if (o_id_pc !== RESET_PC || o_id_inst !== memfn(RESET_PC)) begin
          n_bad++; $display("FAIL rstmid_first got pc=%h inst=%h exp %h/%h", o_id_pc, o_id_inst, RESET_PC, memfn(RESET_PC));
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; last_due = 0; exp_pc = RESET_PC;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_br_coincident();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit RISC-V core. It owns the program counter, issues word-aligned fetch requests to instruction memory, and reorders nothing: responses return in order. It buffers fetched words with their PCs in a small slot queue and presents them to the decode stage, which drives the immediate generator and register file. Branch/jump redirects from execute flush all in-flight and buffered fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, slot-queue entries; also the maximum number of outstanding requests (power of two, ≥2)

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address, bits [1:0] always 0
- imem_rsp_valid  in  1  response word valid; in order, ≥1 cycle after acceptance, no back-pressure
- imem_rsp_data  in  32  instruction word
- br_taken  in  1  redirect from execute, single-cycle pulse
- br_target  in  32  redirect PC; bits [1:0] ignored and forced to 0
- id_valid  out  1  id_inst/id_pc valid to decode
- id_ready  in  1  decode consumes this cycle
- id_inst  out  32  instruction word
- id_pc  out  32  PC of id_inst

## Operation
- State: pc, slot queue (DEPTH entries of {pc, inst, filled}), head/tail pointers, used-count, drop_cnt (pending stale responses).
- Issue: imem_req_valid = !rst && !br_taken && used < DEPTH; imem_req_addr = pc. On acceptance, a slot is allocated at tail with pc written and filled=0, and pc += 4 (wraps mod 2^32).
- An unaccepted request stays stable until accepted, unless br_taken occurs; memory treats a request dropped on redirect as cancelled.
- Response: if drop_cnt > 0, the word is discarded and drop_cnt decrements. Otherwise it fills the oldest unfilled slot.
- Output: id_valid = head slot filled; id_inst/id_pc come from the head slot. Handshake id_valid && id_ready frees head. Outputs stay stable while id_valid && !id_ready.
- Redirect (br_taken): pc ← br_target & ~3. All slots are invalidated and used ← 0. drop_cnt ← number of allocated-but-unfilled slots, minus 1 if a non-dropped response arrives the same cycle. Also added: the old drop_cnt minus 1 if a dropped response arrives this cycle. A decode handshake in the same cycle is ignored; the flush wins.
- Simultaneous free and allocate in one cycle leave used unchanged, which permits full-rate fetch at used = DEPTH-1.
- drop_cnt saturates at 2·DEPTH (cannot be exceeded legally). Assertion: a response arriving with no unfilled slot and drop_cnt = 0 is an error.

## Timing
- Reset values: pc = RESET_PC, used = 0, drop_cnt = 0, id_valid = 0, imem_req_valid = 0 while rst high; id_inst = 0, id_pc = 0.
- First cycle after rst release: imem_req_valid = 1, addr = RESET_PC.
- Latency: response in cycle N gives id_valid in cycle N+1, via the registered slot write.
- Redirect in cycle N: no request in cycle N; id_valid = 0 in N+1; a request to the target is issued in N+1.
- Steady state with 1-cycle memory and id_ready = 1: one instruction per cycle.
- Reset mid-operation clears everything immediately. Stale responses after reset are the memory's responsibility; memory is reset by the same rst.

## Structure
- riscv_pkg: XLEN = 32, ILEN = 32, default RESET_PC constant, and the slot typedef {logic [31:0] pc; logic [31:0] inst; logic filled;}, shared with the decode stage.
- One sub-module: fetch_slot_queue. It holds the DEPTH-entry circular buffer, allocate/fill/pop/flush ports and the used-count. fetch_stage holds pc, drop_cnt and the issue logic.

## Test plan
- Reset release, 1-cycle memory returning 32'h0000_0013 at each address, id_ready = 1: id_pc sequence 0,4,8,… one per cycle. First id_valid appears 2 cycles after release.
- id_ready = 0 for 5 cycles: queue fills to DEPTH, imem_req_valid drops, id_pc/id_inst hold. Releasing id_ready resumes with no lost or duplicated PC.
- br_taken with br_target = 32'h0000_0103 while 2 requests are outstanding: both responses are discarded. Next id_pc = 32'h0000_0100, and no stale word reaches decode.
- br_taken coincident with a response and an id handshake: the flush wins, drop_cnt is correct, and the first id_pc afterwards is the target.
- Variable memory latency (1–4 cycles, random) with random id_ready and random redirects over 10k cycles: in-order PCs from a scoreboard, pc wrap from 32'hFFFF_FFFC to 0, and no assertion hit.
- rst asserted mid-stream with a full queue: all outputs reach reset values asynchronously, and fetch restarts at RESET_PC.
